// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Access sizes, FSM states and UART register offsets.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RMW_WRITE = 2'd1,
    TX_WAIT   = 2'd2
  } state_e;

  localparam logic [31:0] UART_TX_OFF   = 32'h0;
  localparam logic [31:0] UART_STAT_OFF = 32'h4;
  localparam logic [31:0] UART_RX_OFF   = 32'h8;

endpackage

// File: rtl/lsu_mmio_if.sv
// Bus bundle around the LSU: CPU request/response, dmem port, UART port.
// slave = LSU side, master = CPU/memory/UART environment side.
interface lsu_mmio_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        stall;
  logic        misalign;
  logic [31:0] dmem_addr;
  logic        dmem_sel;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_pop;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_addr, req_wdata, dmem_rdata,
    input  uart_tx_ready, uart_rx_data, uart_rx_valid,
    output rsp_rdata, stall, misalign,
    output dmem_addr, dmem_sel, dmem_we, dmem_wdata,
    output uart_tx_data, uart_tx_valid, uart_rx_pop
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_addr, req_wdata, dmem_rdata,
    output uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  rsp_rdata, stall, misalign,
    input  dmem_addr, dmem_sel, dmem_we, dmem_wdata,
    input  uart_tx_data, uart_tx_valid, uart_rx_pop
  );
endinterface

// File: rtl/lsu_align.sv
// Lane logic: merges sub-word store data into a word, extracts loads.
// Ports: i_size/i_unsigned/i_off select lane; o_merged, o_rdata results.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b      = i_word[{i_off, 3'b000} +: 8];
    w_h      = i_word[{i_off[1], 4'b0000} +: 16];
    o_merged = i_word;
    o_rdata  = i_word;
    unique case (1'b1)
      (i_size == SZ_B): begin
        o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
        o_rdata = {{24{~i_unsigned & w_b[7]}}, w_b};
      end
      (i_size == SZ_H): begin
        o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_rdata = {{16{~i_unsigned & w_h[15]}}, w_h};
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit: dmem access with sub-word RMW, UART MMIO, stalls.
// Ports: clk, rst_n, bus (lsu_mmio_if.slave) carrying CPU/dmem/UART.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] UART_BASE  = 32'h8000_0000
) (
  input logic         clk,
  input logic         rst_n,
  lsu_mmio_if.slave   bus
);

  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

  state_e      r_state;
  logic [31:0] r_wbuf;
  logic [9:0]  r_idx;
  logic [7:0]  r_tx_buf;
  logic        r_tx_valid;

  logic        w_act;
  logic        w_mis;
  logic        w_ok;
  logic        w_dmem;
  logic        w_tx;
  logic        w_stat;
  logic        w_rx;
  logic        w_sub;
  logic [31:0] w_merged;
  logic [31:0] w_ld;

  lsu_align u_align (
    .i_size     (bus.req_size),
    .i_unsigned (bus.req_unsigned),
    .i_off      (bus.req_addr[1:0]),
    .i_wdata    (bus.req_wdata),
    .i_word     (bus.dmem_rdata),
    .o_merged   (w_merged),
    .o_rdata    (w_ld)
  );

  // rst_n gates the strobes so they read 0 while reset is held
  always_comb begin
    w_act  = bus.req_valid & rst_n & (r_state == IDLE);
    w_mis  = ((bus.req_size == SZ_H) & bus.req_addr[0])
           | (bus.req_size[1] & (bus.req_addr[1:0] != 2'b00));
    w_ok   = w_act & ~w_mis;
    w_sub  = ~bus.req_size[1];
    w_dmem = bus.req_addr < DMEM_BYTES;
    w_tx   = bus.req_addr == UART_BASE + UART_TX_OFF;
    w_stat = bus.req_addr == UART_BASE + UART_STAT_OFF;
    w_rx   = bus.req_addr == UART_BASE + UART_RX_OFF;
  end

  always_comb begin
    bus.rsp_rdata   = '0;
    bus.stall       = 1'b0;
    bus.misalign    = w_act & w_mis;
    bus.dmem_sel    = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.dmem_addr   = {22'b0, bus.req_addr[11:2]};
    bus.dmem_wdata  = bus.req_wdata;
    bus.uart_rx_pop = 1'b0;
    if (r_state == RMW_WRITE) begin
      bus.dmem_sel   = 1'b1;
      bus.dmem_we    = 1'b1;
      bus.dmem_addr  = {22'b0, r_idx};
      bus.dmem_wdata = r_wbuf;
    end
    if (r_state == TX_WAIT)
      bus.stall = ~bus.uart_tx_ready;
    if (w_ok) begin
      unique case (1'b1)
        w_dmem: begin
          bus.dmem_sel = 1'b1;
          if (!bus.req_we)
            bus.rsp_rdata = w_ld;
          else if (w_sub)
            bus.stall = 1'b1;
          else
            bus.dmem_we = 1'b1;
        end
        w_tx: bus.stall = bus.req_we;
        w_stat: begin
          if (!bus.req_we)
            bus.rsp_rdata = {30'b0, bus.uart_rx_valid,
                             ~bus.uart_tx_ready | r_tx_valid};
        end
        w_rx: begin
          if (!bus.req_we && bus.uart_rx_valid) begin
            bus.rsp_rdata   = {24'b0, bus.uart_rx_data};
            bus.uart_rx_pop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wbuf     <= '0;
      r_idx      <= '0;
      r_tx_buf   <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_ok && bus.req_we && w_dmem && w_sub) begin
            r_wbuf  <= w_merged;
            r_idx   <= bus.req_addr[11:2];
            r_state <= RMW_WRITE;
          end else if (w_ok && bus.req_we && w_tx) begin
            r_tx_buf   <= bus.req_wdata[7:0];
            r_tx_valid <= 1'b1;
            r_state    <= TX_WAIT;
          end
        end
        RMW_WRITE: r_state <= IDLE;
        TX_WAIT: begin
          if (r_tx_valid && bus.uart_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.uart_tx_data  = r_tx_buf;
  assign bus.uart_tx_valid = r_tx_valid;

endmodule
